onehot_scan_encoder: RTL and testbench
======================================

# onehot_scan_encoder

Sequential encoder for the one-hot/multi-hot vectors that our `decoder` produces.
- Captures a 2^WIDTH-bit vector on `load`.
- Emits the binary index of every set bit, lowest index first, one per valid/ready handshake.
- Pulses `done` when the captured vector is exhausted.
- Sits on the RRAM row/column select path. It converts row-enable or flag vectors back into addresses for readback, checking and status reporting. It is the inverse of the binary-to-one-hot decoder.

## Interface
Parameters
- WIDTH, 4, binary index width. The captured vector is N = 1 << WIDTH bits wide.

Ports
- clk  input  1  system clock; all state changes on its rising edge
- rst_n  input  1  reset, synchronous and active-low, sampled on the rising edge of `clk`
- load  input  1  capture request; honoured only in IDLE
- onehot_in  input  N  vector to encode; sampled when `load` is honoured
- ready  input  1  downstream accepts `binary_out` in this cycle
- binary_out  output  WIDTH  index of the lowest set bit still pending
- valid  output  1  `binary_out` holds a pending index
- busy  output  1  block is in EMIT (captured vector not yet exhausted)
- done  output  1  one-cycle pulse when a capture has been fully emitted
- multi_hot  output  1  last captured vector had more than one bit set
- count  output  WIDTH+1  number of indices emitted since the last honoured `load`

## Operation
- State machine: two states.
  - IDLE (reset state): `busy`=0, `valid`=0.
  - EMIT: `busy`=1, `valid`=1.
- Reset (rst_n=0 at an edge) has priority over everything and sets:
  - state=IDLE, pending register=0;
  - `count`=0, `multi_hot`=0, `done`=0;
  - hence `binary_out`=0, `valid`=0, `busy`=0.
- IDLE with `load`=1, at the edge:
  - pending <= onehot_in;
  - `count` <= 0;
  - `multi_hot` <= (popcount(onehot_in) > 1).
  - If onehot_in != 0: state <= EMIT.
  - If onehot_in == 0: stay in IDLE and set `done` <= 1. No index is ever emitted.
- EMIT:
  - `binary_out` is the combinational priority encode (lowest index) of pending.
  - `valid` = (state == EMIT).
- Transfer: occurs on an edge where `valid`=1 and `ready`=1. At that edge:
  - the bit at `binary_out` is cleared in pending;
  - `count` increments by 1.
  - If that was the last set bit: state <= IDLE and `done` <= 1.
- `done` is registered. It is high for exactly one cycle following the completing edge, then returns to 0.
- `load` during EMIT is ignored: no capture, and `count`/`multi_hot` are unchanged.
- `ready` while `valid`=0 has no effect.
- `count` never wraps: its maximum is N, which fits in WIDTH+1 bits.
- `multi_hot` and `count` hold their values in IDLE until the next honoured `load` or reset.

## Timing
- Load-to-first-valid latency: 1 cycle. For `load` sampled at edge k, `valid`=1 after edge k.
- Throughput: one index per cycle while `ready`=1.
  - A vector with P set bits completes P cycles after the first `valid`.
  - `done` is high during the cycle after the last transfer edge.
- Zero vector: `done` is high the cycle after the load edge; `valid` stays 0.
- Stall: while `valid`=1 and `ready`=0, `binary_out`, `valid` and `count` stay stable.
- Back-to-back: a `load` can be honoured in the same cycle `done` is high, because the state is already IDLE.
- Reset mid-EMIT: outputs reach their reset values after the reset edge. The aborted vector is discarded and `done` does not pulse.

## Test plan
- Reset: hold rst_n=0 for 2 edges with `load`=1 and onehot_in=16'hFFFF. Required: `valid`=0, `busy`=0, `done`=0, `count`=0, `multi_hot`=0, `binary_out`=0.
- Single bit: load 16'h0010 with `ready`=1. Required:
  - next cycle: `valid`=1, `binary_out`=4;
  - following cycle: `done`=1, `count`=1, `multi_hot`=0, `busy`=0.
- Stall and order: load 16'h8001 with `ready`=0 for 3 cycles. Required:
  - during the stall: `binary_out`=0 held stable and `count`=0;
  - then with `ready`=1: `binary_out`=0, then 15; `count` ends at 2, `multi_hot`=1, one `done` pulse.
- Zero vector and ignored load:
  - Load 0. Required: `done` pulses the next cycle and `valid` never rises.
  - Load 16'h0006, then assert `load` with 16'h0100 while busy. Required: only indices 1 and 2 are emitted.
- Reset mid-operation: load 16'hFFFF, accept 3 indices, then pulse rst_n=0. Required: `valid`=0 and `count`=0 after the edge, with no `done` pulse.
- Round trip with `decoder` (WIDTH=4, enable=1): for every index i in 0..15, load the decoder output. Required: exactly one transfer with `binary_out`=i and `count`=1.

Source files
------------

// File: rtl/onehot_scan_encoder.sv
// onehot_scan_encoder
//   Captures a 2^WIDTH-bit one-hot or multi-hot vector. It then emits the
//   binary index of every set bit, lowest index first. One index is emitted
//   per valid/ready transfer. This is the inverse of the binary-to-one-hot
//   decoder on the row/column select path.
//
// Ports
//   clk         system clock, rising edge
//   rst_n       synchronous active-low reset
//   load        capture request, honoured only in IDLE
//   onehot_in   vector to capture (N = 1 << WIDTH bits)
//   ready       downstream accepts binary_out this cycle
//   binary_out  index of lowest pending set bit
//   valid       binary_out holds a pending index (state EMIT)
//   busy        captured vector not yet exhausted (state EMIT)
//   done        one-cycle pulse after a capture is fully emitted
//   multi_hot   last captured vector had more than one bit set
//   count       indices emitted since the last honoured load
module onehot_scan_encoder #(
  parameter int WIDTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   load,
  input  logic [(1<<WIDTH)-1:0]  onehot_in,
  input  logic                   ready,
  output logic [WIDTH-1:0]       binary_out,
  output logic                   valid,
  output logic                   busy,
  output logic                   done,
  output logic                   multi_hot,
  output logic [WIDTH:0]         count
);

  localparam int N = 1 << WIDTH;

  typedef enum logic {IDLE = 1'b0, EMIT = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [N-1:0]     pend_q, pend_d;
  logic [WIDTH:0]   count_q, count_d;
  logic             multi_q, multi_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] enc;
  logic [N-1:0]     pend_clr;
  logic             xfer;
  logic             last;

  // Lowest-index priority encode. The loop runs downward so the lowest
  // set bit is assigned last and wins.
  always_comb begin
    enc = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (pend_q[i]) enc = WIDTH'(i);
    end
  end

  always_comb begin
    pend_clr      = pend_q;
    pend_clr[enc] = 1'b0;
  end

  assign xfer = (state_q == EMIT) && ready;
  assign last = (pend_clr == '0);

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (load && (onehot_in != '0)) state_d = EMIT;
      EMIT: if (xfer && last)              state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath next-state
  always_comb begin
    pend_d  = pend_q;
    count_d = count_q;
    multi_d = multi_q;
    done_d  = 1'b0;
    if (state_q == IDLE) begin
      if (load) begin
        pend_d  = onehot_in;
        count_d = '0;
        // x & (x-1) clears the lowest set bit, so a nonzero result means
        // at least two bits are set.
        multi_d = ((onehot_in & (onehot_in - N'(1))) != '0);
        done_d  = (onehot_in == '0);
      end
    end else if (xfer) begin
      pend_d  = pend_clr;
      count_d = count_q + (WIDTH+1)'(1);
      done_d  = last;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend_q  <= '0;
      count_q <= '0;
      multi_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      pend_q  <= pend_d;
      count_q <= count_d;
      multi_q <= multi_d;
      done_q  <= done_d;
    end
  end

  // Output logic
  always_comb begin
    valid      = (state_q == EMIT);
    busy       = (state_q == EMIT);
    binary_out = enc;
    done       = done_q;
    multi_hot  = multi_q;
    count      = count_q;
  end

endmodule

// File: tb/tb_onehot_scan_encoder.sv
module tb_onehot_scan_encoder;
  localparam int WIDTH = 4;
  localparam int N = 1 << WIDTH;

  logic             clk = 1'b0;
  logic             rst_n, load, ready;
  logic [N-1:0]     onehot_in;
  logic [WIDTH-1:0] binary_out;
  logic             valid, busy, done, multi_hot;
  logic [WIDTH:0]   count;

  int n_assert = 0;
  int n_fail   = 0;

  onehot_scan_encoder #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .onehot_in(onehot_in),
    .ready(ready), .binary_out(binary_out), .valid(valid), .busy(busy),
    .done(done), .multi_hot(multi_hot), .count(count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, then settle before sampling.
  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [N-1:0] dec;

    // Reset with an aggressive load pending
    rst_n = 1'b0; load = 1'b1; onehot_in = 16'hFFFF; ready = 1'b0;
    step; step;
    chk("rst_valid", valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_count", count, 0);
    chk("rst_multi", multi_hot, 0);
    chk("rst_bout", binary_out, 0);
    rst_n = 1'b1; load = 1'b0;
    step;
    chk("idle_valid", valid, 0);

    // Single bit
    load = 1'b1; onehot_in = 16'h0010; ready = 1'b1;
    step;
    chk("single_valid", valid, 1);
    chk("single_bout", binary_out, 4);
    chk("single_busy", busy, 1);
    load = 1'b0;
    step;
    chk("single_done", done, 1);
    chk("single_count", count, 1);
    chk("single_multi", multi_hot, 0);
    chk("single_busy2", busy, 0);
    chk("single_valid2", valid, 0);
    step;
    chk("single_done_drop", done, 0);

    // Stall and order
    load = 1'b1; onehot_in = 16'h8001; ready = 1'b0;
    step;
    chk("stall_valid", valid, 1);
    chk("stall_bout0", binary_out, 0);
    chk("stall_cnt0", count, 0);
    chk("stall_multi", multi_hot, 1);
    load = 1'b0;
    step;
    chk("stall_bout1", binary_out, 0);
    chk("stall_cnt1", count, 0);
    step;
    chk("stall_bout2", binary_out, 0);
    chk("stall_cnt2", count, 0);
    chk("stall_valid2", valid, 1);
    ready = 1'b1;
    step;
    chk("order_bout15", binary_out, 15);
    chk("order_cnt1", count, 1);
    chk("order_nodone", done, 0);
    step;
    chk("order_done", done, 1);
    chk("order_cnt2", count, 2);
    chk("order_valid", valid, 0);
    chk("order_multi", multi_hot, 1);
    step;
    chk("order_done_once", done, 0);

    // Zero vector
    load = 1'b1; onehot_in = 16'h0000;
    step;
    chk("zero_done", done, 1);
    chk("zero_valid", valid, 0);
    chk("zero_count", count, 0);
    chk("zero_multi", multi_hot, 0);
    load = 1'b0;
    step;
    chk("zero_done_drop", done, 0);
    chk("zero_valid2", valid, 0);

    // Load while busy is ignored
    load = 1'b1; onehot_in = 16'h0006; ready = 1'b0;
    step;
    chk("ign_valid", valid, 1);
    chk("ign_bout1", binary_out, 1);
    onehot_in = 16'h0100; ready = 1'b1;
    step;
    chk("ign_bout2", binary_out, 2);
    chk("ign_cnt1", count, 1);
    chk("ign_multi", multi_hot, 1);
    load = 1'b0;
    step;
    chk("ign_done", done, 1);
    chk("ign_cnt2", count, 2);
    chk("ign_valid_end", valid, 0);
    step;
    chk("ign_no_reload", valid, 0);
    chk("ign_done_drop", done, 0);

    // Reset mid-operation
    load = 1'b1; onehot_in = 16'hFFFF; ready = 1'b1;
    step;
    chk("mid_bout0", binary_out, 0);
    load = 1'b0;
    step;
    chk("mid_bout1", binary_out, 1);
    step;
    chk("mid_bout2", binary_out, 2);
    step;
    chk("mid_bout3", binary_out, 3);
    chk("mid_cnt3", count, 3);
    rst_n = 1'b0;
    step;
    chk("mid_rst_valid", valid, 0);
    chk("mid_rst_count", count, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_multi", multi_hot, 0);
    rst_n = 1'b1; ready = 1'b0;
    step;
    chk("mid_rst_nodone", done, 0);
    chk("mid_rst_valid2", valid, 0);

    // Round trip with decoder outputs
    ready = 1'b1;
    for (int i = 0; i < N; i++) begin
      dec = '0;
      dec[i] = 1'b1;
      load = 1'b1; onehot_in = dec;
      step;
      chk($sformatf("rt%0d_valid", i), valid, 1);
      chk($sformatf("rt%0d_bout", i), binary_out, i);
      load = 1'b0;
      step;
      chk($sformatf("rt%0d_done", i), done, 1);
      chk($sformatf("rt%0d_count", i), count, 1);
      chk($sformatf("rt%0d_valid_end", i), valid, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
